// File: rtl/fifo_pkg.sv
// Shared constants for the synchronous FIFO: default geometry and a depth helper
// used by both the pointer controller and the storage top level.
package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_BITS  = 3;
  localparam int DEPTH          = 1 << DEF_ADDR_BITS;

  function automatic int depthOf(input int addrBits);
    return 1 << addrBits;
  endfunction

endpackage

// File: rtl/fifo_ctrl.sv
// Pointer bookkeeping for the FIFO: accept decisions, wrap-bit pointers and
// the full/empty flags derived from them.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_BITS = DEF_ADDR_BITS
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 wr_i,
  input  logic                 rd_i,
  output logic                 wrEn_o,
  output logic                 rdEn_o,
  output logic [ADDR_BITS-1:0] waddr_o,
  output logic [ADDR_BITS-1:0] raddr_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam logic [ADDR_BITS:0] PtrStep = {{ADDR_BITS{1'b0}}, 1'b1};

  logic [ADDR_BITS:0] wptr_q, wptr_d;
  logic [ADDR_BITS:0] rptr_q, rptr_d;
  logic               wrAccept, rdAccept;

  // Flags come straight from the registered pointers; the extra MSB tells a
  // completely full buffer apart from an empty one when the low bits match.
  always_comb begin
    empty_o = (wptr_q == rptr_q);
    full_o  = (wptr_q[ADDR_BITS-1:0] == rptr_q[ADDR_BITS-1:0]) &&
              (wptr_q[ADDR_BITS] != rptr_q[ADDR_BITS]);
  end

  // A write into a full buffer is still fine when a read frees a slot on the same edge.
  always_comb begin
    rdAccept = rd_i && !empty_o && !rst_i;
    wrAccept = wr_i && (!full_o || rdAccept) && !rst_i;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    if (wrAccept) wptr_d = wptr_q + PtrStep;
    if (rdAccept) rptr_d = rptr_q + PtrStep;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  assign wrEn_o  = wrAccept;
  assign rdEn_o  = rdAccept;
  assign waddr_o = wptr_q[ADDR_BITS-1:0];
  assign raddr_o = rptr_q[ADDR_BITS-1:0];

endmodule

// File: rtl/fifo.sv
// Synchronous FIFO top level: register-array storage and the registered read
// port, with pointer control delegated to fifo_ctrl.
module fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_BITS  = DEF_ADDR_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [DATA_WIDTH-1:0] Din,
  output logic [DATA_WIDTH-1:0] Dout,
  output logic                  full,
  output logic                  empty
);

  localparam int MemDepth = depthOf(ADDR_BITS);

  logic [DATA_WIDTH-1:0] mem_q [MemDepth];
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  wrEn, rdEn;
  logic [ADDR_BITS-1:0]  waddr, raddr;

  fifo_ctrl #(
    .ADDR_BITS(ADDR_BITS)
  ) u_ctrl (
    .clk_i  (clk),
    .rst_i  (rst),
    .wr_i   (wr),
    .rd_i   (rd),
    .wrEn_o (wrEn),
    .rdEn_o (rdEn),
    .waddr_o(waddr),
    .raddr_o(raddr),
    .full_o (full),
    .empty_o(empty)
  );

  // Storage is deliberately left unreset; stale words are unreachable because
  // reads are only accepted while the pointers say data is present.
  always_ff @(posedge clk) begin
    if (wrEn) mem_q[waddr] <= Din;
  end

  always_comb begin
    dout_d = dout_q;
    if (rdEn) dout_d = mem_q[raddr];
  end

  always_ff @(posedge clk) begin
    if (rst) dout_q <= '0;
    else     dout_q <= dout_d;
  end

  assign Dout = dout_q;

endmodule

// File: tb/tb_fifo.sv
// Randomised and directed bench for fifo: a queue-based reference model feeds a
// scoreboard that a separate monitor drains once per clock.
module tb_fifo;

  localparam int DW    = fifo_pkg::DEF_DATA_WIDTH;
  localparam int DEPTH = fifo_pkg::DEPTH;

  typedef struct {
    logic [DW-1:0] dout;
    logic          full;
    logic          empty;
    int            cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr  = 1'b0;
  logic          rd  = 1'b0;
  logic [DW-1:0] Din = '0;
  logic [DW-1:0] Dout;
  logic          full, empty;

  exp_t          expQ[$];
  logic [DW-1:0] modelQ[$];
  logic [DW-1:0] modelDout = '0;
  int            cycle      = 0;
  int            compared   = 0;
  int            mismatched = 0;
  logic [DW-1:0] nextDin    = 8'd1;

  fifo dut (
    .clk  (clk),
    .rst  (rst),
    .wr   (wr),
    .rd   (rd),
    .Din  (Din),
    .Dout (Dout),
    .full (full),
    .empty(empty)
  );

  always #5 clk = ~clk;

  // Drives one cycle of inputs and records what the FIFO must show after the next edge.
  task automatic applyStimulus(input logic r, input logic w, input logic rq, input logic [DW-1:0] d);
    exp_t e;
    logic rdAcc, wrAcc;
    @(negedge clk);
    rst = r;
    wr  = w;
    rd  = rq;
    Din = d;
    if (r) begin
      modelQ.delete();
      modelDout = '0;
    end else begin
      rdAcc = rq && (modelQ.size() > 0);
      wrAcc = w && ((modelQ.size() < DEPTH) || rdAcc);
      if (rdAcc) modelDout = modelQ.pop_front();
      if (wrAcc) modelQ.push_back(d);
    end
    e.dout  = modelDout;
    e.full  = (modelQ.size() == DEPTH);
    e.empty = (modelQ.size() == 0);
    e.cyc   = cycle;
    cycle++;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    compared++;
    if (Dout !== e.dout) begin
      mismatched++;
      $display("[TB] FAIL dout cyc=%0d got=%0h want=%0h", e.cyc, Dout, e.dout);
    end
    compared++;
    if (full !== e.full) begin
      mismatched++;
      $display("[TB] FAIL full cyc=%0d got=%b want=%b", e.cyc, full, e.full);
    end
    compared++;
    if (empty !== e.empty) begin
      mismatched++;
      $display("[TB] FAIL empty cyc=%0d got=%b want=%b", e.cyc, empty, e.empty);
    end
  endtask

  task automatic writeSeq(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, nextDin);
      nextDin++;
    end
  endtask

  task automatic readSeq(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b1, '0);
  endtask

  task automatic bothSeq(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, nextDin);
      nextDin++;
    end
  endtask

  // Monitor: samples shortly after each rising edge, away from input changes.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    #1000000;
    mismatched++;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    int pw, pr;
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);

    nextDin = 8'd1;
    writeSeq(9);
    readSeq(10);

    applyStimulus(1'b0, 1'b1, 1'b1, 8'hA5);
    readSeq(2);

    writeSeq(4);
    bothSeq(20);
    readSeq(5);

    writeSeq(DEPTH);
    bothSeq(2);
    readSeq(DEPTH + 1);

    writeSeq(5);
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h77);
    applyStimulus(1'b0, 1'b0, 1'b1, '0);
    applyStimulus(1'b0, 1'b0, 1'b1, '0);

    for (int i = 0; i < 400; i++) begin
      pw = (i < 200) ? 75 : 40;
      pr = (i < 200) ? 40 : 75;
      applyStimulus(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 99) < pw) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 99) < pr) ? 1'b1 : 1'b0,
                    DW'($urandom_range(0, 255)));
    end
    applyStimulus(1'b0, 1'b0, 1'b0, '0);

    repeat (3) @(posedge clk);
    #3;
    compared++;
    if (expQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL drain got=%0d want=0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fifo.md
FIFO -- requirements
Module: fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8, data word width in bits.
REQ-002 Parameter ADDR_BITS, default 3, address width; depth SHALL be 2**ADDR_BITS (8 entries by default).
REQ-003 clk  input  1  single clock; all state updates SHALL occur on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 wr  input  1  write request; Din is written when wr=1 and the write is accepted.
REQ-006 rd  input  1  read request; pops the oldest entry when rd=1 and the read is accepted.
REQ-007 Din  input  DATA_WIDTH  write data.
REQ-008 Dout  output  DATA_WIDTH  read data, registered.
REQ-009 full  output  1  high when the FIFO holds 2**ADDR_BITS entries.
REQ-010 empty  output  1  high when the FIFO holds 0 entries.

Function
REQ-011 Storage SHALL be a 2**ADDR_BITS x DATA_WIDTH register array with write and read pointers.
- Each pointer is ADDR_BITS+1 bits; the extra MSB is a wrap bit.
REQ-012 A write SHALL be accepted when wr=1 and (full=0 or a read is accepted in the same cycle).
- On acceptance: mem[wptr] <= Din and wptr increments modulo 2**(ADDR_BITS+1).
REQ-013 A read SHALL be accepted when rd=1 and empty=0.
- On acceptance: Dout <= mem[rptr] and rptr increments.
REQ-014 Read latency SHALL be one cycle: the popped word appears on Dout after the rising edge that accepts the read.
- Dout SHALL hold its value when no read is accepted.
REQ-015 Flag definitions:
- empty SHALL be 1 iff wptr == rptr.
- full SHALL be 1 iff the low ADDR_BITS bits are equal and the MSBs differ.
- Both flags are combinational from the registered pointers, so they are valid the cycle after the pointer update.
REQ-016 A write while full with no accepted read SHALL be ignored: no pointer, memory or flag change and no error.
REQ-017 A read while empty SHALL be ignored: Dout holds its value and rptr is unchanged.
REQ-018 Simultaneous wr and rd when empty: only the write SHALL take effect.
- empty deasserts next cycle; there is no bypass of Din to Dout.
REQ-019 Simultaneous wr and rd when full: both SHALL take effect and full remains 1.
REQ-020 Simultaneous wr and rd when partially full: both SHALL take effect and occupancy is unchanged.
REQ-021 Pointer wrap-around SHALL be seamless, preserving FIFO order across any number of wraps.
REQ-022 Data SHALL be output in exact write order with no loss or duplication.

Reset
REQ-023 While rst=1 at a rising clk edge, the block SHALL:
- set wptr=0, rptr=0 and Dout=0;
- give empty=1 and full=0 from the next cycle;
- ignore wr and rd.
REQ-024 Memory contents SHALL NOT be reset.
- Stale data SHALL never be readable, since reads require empty=0.
REQ-025 Reset asserted mid-operation SHALL discard all stored entries, leaving the block immediately usable on the first cycle after rst deasserts.

Structure
REQ-026 Package fifo_pkg SHALL hold the DATA_WIDTH and ADDR_BITS defaults and a derived DEPTH constant.
REQ-027 One sub-module, fifo_ctrl, SHALL contain the pointer registers, accept logic and full/empty generation.
- The top-level fifo SHALL hold the memory array and the Dout register.

Verification
REQ-028 Reset then idle: rst=1 for one edge -> empty=1, full=0, Dout=0.
REQ-029 Fill: after reset, write Din=1,2,3,... one per cycle until full.
- full=1 after the 8th write (Din=8).
- A 9th write (Din=9) is ignored and full stays 1.
REQ-030 Drain: from full, hold rd=1.
- Dout shows 1,2,...,8 on consecutive cycles.
- empty=1 after the 8th read; further reads leave Dout=8.
REQ-031 Wrap: run 20 cycles of concurrent wr/rd at half occupancy with Din incrementing -> Dout sequence strictly increasing by 1 with no gaps.
REQ-032 Boundary simultaneity:
- wr+rd when empty -> only the write occurs, empty=0 next cycle.
- wr+rd when full -> full stays 1 and the oldest word appears on Dout.
REQ-033 Mid-operation reset: write 5 words, assert rst -> empty=1, full=0; a subsequent single write/read returns the new word.
